ahbsub_mem: RTL and testbench
=============================

// Module: ahbsub_mem
// PURPOSE
//  32-bit AHB subordinate (responder) memory model: the far end of the ahbbfm manager in test benches.
//  Pipelined address/data phases, programmable wait states, SINGLE/INCR bursts, byte strobes.
//  Optional two-cycle ERROR response for out-of-range or oversize accesses.
// PARAMETERS
//  ADDRWIDTH   32  address width (fixed; do not change)
//  DATAWIDTH   32  data width (fixed; do not change)
//  MEMWORDS_LOG2 12  log2 of memory depth in 32-bit words (default 4096 words = 16KB)
//  WAITSTATES  0   wait cycles (HREADYOUT low) inserted per transfer, range 0-15
//  BASEADDR    0   byte base address of the memory window (aligned to window size)
// PORTS
//  hclk       in   1   clock, all logic on rising edge
//  hresetn    in   1   asynchronous active-low reset
//  hsel       in   1   subordinate select
//  haddr      in   32  byte address
//  htrans     in   2   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//  hwrite     in   1   1=write, 0=read
//  hsize      in   3   transfer size (0=byte,1=half,2=word)
//  hburst     in   3   burst type (accepted, not checked)
//  hmastlock  in   1   ignored
//  hwstrb     in   4   write byte strobes (data phase)
//  hwdata     in   32  write data (data phase)
//  hready     in   1   bus ready (tie to hreadyout when single subordinate)
//  hrdata     out  32  read data
//  hreadyout  out  1   transfer complete / subordinate ready
//  hresp      out  1   0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset: hreadyout=1, hresp=0, hrdata=0, state=IDLE, wait counter=0; memory contents not cleared.
//  Address phase accepted on posedge when hsel & hready & htrans[1]; latch haddr, hwrite, hsize.
//  Not accepted (IDLE, BUSY, hsel=0): next cycle is zero-wait OKAY (hreadyout=1, hresp=0).
//  FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//   IDLE->WAIT on accept if WAITSTATES>0 (counter loaded WAITSTATES-1); ->DATA if WAITSTATES=0; ->ERR1 if error.
//   WAIT: hreadyout=0, hresp=0; decrement counter; ->DATA when counter=0.
//   DATA: hreadyout=1, hresp=0; transfer completes this cycle. New accept -> WAIT/DATA/ERR1; else IDLE.
//   ERR1: hreadyout=0, hresp=1. Always ->ERR2.
//   ERR2: hreadyout=1, hresp=1; completes; new accept handled as from DATA (manager may also send IDLE).
//  Latency: transfer data phase lasts WAITSTATES+1 cycles; back-to-back pipelined transfers, no bubble.
//  Word index = haddr[MEMWORDS_LOG2+1:2] - BASEADDR word offset; haddr[1:0] ignored for indexing.
//  Write: at end of DATA cycle, byte lane i of mem[index] <= hwdata[8i+7:8i] where hwstrb[i]=1.
//  Read: hrdata = mem[index] valid in the cycle hreadyout=1 of DATA; hrdata holds prior value otherwise.
//  Write then read same address in consecutive transfers: read returns newly written data (bypass).
//  hwstrb=0 write: completes OKAY, memory unchanged.
//  Reset mid-transfer: FSM to IDLE immediately, pending write discarded, outputs to reset values.
//  INCR bursts: each SEQ beat treated as independent transfer, wait states applied per beat.
// CONFIGURATION
//  AHB_SUB_ERR_EN defined: ERROR (ERR1->ERR2) when address outside
//   [BASEADDR, BASEADDR+4*2^MEMWORDS_LOG2) or hsize>2; erroring write leaves memory unchanged,
//   erroring read drives hrdata=0.
//  AHB_SUB_ERR_EN undefined: no ERR states; hresp tied 0; out-of-range addresses alias
//   (index wraps modulo 2^MEMWORDS_LOG2); hsize>2 treated as word.
// TESTING
//  Reset: assert hresetn=0 mid-WAIT -> hreadyout=1, hresp=0, hrdata=0 same cycle.
//  WAITSTATES=0: NONSEQ write 0x0000_0010 data 0xDEADBEEF strb 0xF, then read -> 0xDEADBEEF, no wait cycles.
//  WAITSTATES=2: single read -> hreadyout low exactly 2 cycles then high with data.
//  Strobes: write 0x11223344 strb 0xF, write 0xAABBCCDD strb 0x5 same addr, read -> 0x11BB33DD.
//  INCR burst of 4 writes from 0x100 (NONSEQ,SEQ,SEQ,SEQ) then 4-beat read -> same 4 words in order.
//  AHB_SUB_ERR_EN, MEMWORDS_LOG2=12: read 0x0000_4000 -> cycle1 ready=0 resp=1, cycle2 ready=1 resp=1;
//   without macro same read returns mem[0].

Source files
------------

// File: rtl/ahbsub_mem.sv
// ahbsub_mem: 32-bit AHB subordinate memory model for test benches.
// Handles pipelined address/data phases, a fixed number of wait states per
// transfer (WAITSTATES), SINGLE/INCR bursts beat by beat, and byte strobes.
// The memory contents are never cleared, not even by reset.
//
// Optional feature macro: AHB_SUB_ERR_EN
//   defined   : out-of-window addresses or hsize>2 get a two-cycle ERROR
//               response (ERR1 then ERR2); such writes are dropped and
//               such reads return zero.
//   undefined : hresp stays 0, addresses alias modulo the memory depth,
//               and any hsize is treated as a word access.
//
// Ports:
//   hclk, hresetn    clock (rising edge), asynchronous active-low reset
//   hsel, haddr      select, byte address
//   htrans           IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   hwrite, hsize    direction, transfer size
//   hburst, hmastlock  accepted but ignored
//   hwstrb, hwdata   write strobes and write data (data phase)
//   hready           bus ready input
//   hrdata           read data
//   hreadyout        subordinate ready
//   hresp            0=OKAY, 1=ERROR
module ahbsub_mem #(
  parameter int          ADDRWIDTH     = 32,
  parameter int          DATAWIDTH     = 32,
  parameter int          MEMWORDS_LOG2 = 12,
  parameter int          WAITSTATES    = 0,
  parameter logic [31:0] BASEADDR      = 32'h0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   hsel,
  input  logic [ADDRWIDTH-1:0]   haddr,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic [2:0]             hburst,
  input  logic                   hmastlock,
  input  logic [DATAWIDTH/8-1:0] hwstrb,
  input  logic [DATAWIDTH-1:0]   hwdata,
  input  logic                   hready,
  output logic [DATAWIDTH-1:0]   hrdata,
  output logic                   hreadyout,
  output logic                   hresp
);

  localparam int LANES = DATAWIDTH / 8;
  localparam logic [MEMWORDS_LOG2-1:0] BASE_IDX = BASEADDR[MEMWORDS_LOG2+1:2];

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                   state, state_nxt;
  logic [3:0]               cnt, cnt_nxt;
  logic                     take;
  logic                     err_in;
  logic [MEMWORDS_LOG2-1:0] idx_in;
  logic [MEMWORDS_LOG2-1:0] idx_p1;
  logic                     write_p1;
  logic                     wr_commit;
  logic [MEMWORDS_LOG2-1:0] rd_idx;
  logic                     rd_is_wr;
  logic [DATAWIDTH-1:0]     rd_word;
  logic [DATAWIDTH-1:0]     mem [0:(1<<MEMWORDS_LOG2)-1];
  logic                     unused_ok;

  function automatic logic [DATAWIDTH-1:0] merge_lanes(
    input logic [DATAWIDTH-1:0] old_w,
    input logic [DATAWIDTH-1:0] new_w,
    input logic [LANES-1:0]     strb
  );
    logic [DATAWIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < LANES; i++)
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  assign unused_ok = ^{hburst, hmastlock, hsize, haddr};

  // Address phase: a new transfer can only be taken while the previous one
  // is finishing (or the bus is idle), never during WAIT or ERR1.
  assign take   = hsel && hready && htrans[1] &&
                  (state != ST_WAIT) && (state != ST_ERR1);
  assign idx_in = haddr[MEMWORDS_LOG2+1:2] - BASE_IDX;

`ifdef AHB_SUB_ERR_EN
  localparam logic [ADDRWIDTH:0] WIN_LO = {1'b0, BASEADDR[ADDRWIDTH-1:0]};
  localparam logic [ADDRWIDTH:0] WIN_HI = WIN_LO + ((ADDRWIDTH+1)'(4) << MEMWORDS_LOG2);
  assign err_in = ({1'b0, haddr} < WIN_LO) || ({1'b0, haddr} >= WIN_HI) ||
                  (hsize > 3'd2);
`else
  assign err_in = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (cnt == 4'd0) state_nxt = ST_DATA;
        else             cnt_nxt   = cnt - 4'd1;
      end
`ifdef AHB_SUB_ERR_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ST_ERR2;
      end
`endif
      default: begin
`ifdef AHB_SUB_ERR_EN
        if (state == ST_ERR2) hresp = 1'b1;
`endif
        if (!take) begin
          state_nxt = ST_IDLE;
        end else if (err_in) begin
          state_nxt = ST_ERR1;
        end else if (WAITSTATES > 0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = 4'(WAITSTATES - 1);
        end else begin
          state_nxt = ST_DATA;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)  write_p1 <= 1'b0;
    else if (take) write_p1 <= hwrite;
  end

  always_ff @(posedge hclk) begin
    if (take) idx_p1 <= idx_in;
  end

  // Data phase: a write lands at the end of its DATA cycle. A read entering
  // DATA on the same edge picks the merged word so write-then-read works.
  assign wr_commit = (state == ST_DATA) && write_p1;
  assign rd_idx    = (state == ST_WAIT) ? idx_p1   : idx_in;
  assign rd_is_wr  = (state == ST_WAIT) ? write_p1 : hwrite;
  assign rd_word   = (wr_commit && (idx_p1 == rd_idx)) ?
                     merge_lanes(mem[idx_p1], hwdata, hwstrb) : mem[rd_idx];

  always_ff @(posedge hclk) begin
    if (wr_commit) mem[idx_p1] <= merge_lanes(mem[idx_p1], hwdata, hwstrb);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      hrdata <= '0;
    else if ((state_nxt == ST_DATA) && !rd_is_wr)
      hrdata <= rd_word;
    else if ((state_nxt == ST_ERR1) && !hwrite)
      hrdata <= '0;
  end

endmodule

// File: tb/tb_ahbsub_mem.sv
module tb_ahbsub_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: no wait states
  logic        a_rstn, a_hsel, a_hwrite, a_hmastlock;
  logic [31:0] a_haddr, a_hwdata;
  logic [1:0]  a_htrans;
  logic [2:0]  a_hsize, a_hburst;
  logic [3:0]  a_hwstrb;
  logic [31:0] a_hrdata;
  logic        a_hreadyout, a_hresp, a_hready;
  assign a_hready = a_hreadyout;

  // Instance B: two wait states
  logic        b_rstn, b_hsel, b_hwrite, b_hmastlock;
  logic [31:0] b_haddr, b_hwdata;
  logic [1:0]  b_htrans;
  logic [2:0]  b_hsize, b_hburst;
  logic [3:0]  b_hwstrb;
  logic [31:0] b_hrdata;
  logic        b_hreadyout, b_hresp, b_hready;
  assign b_hready = b_hreadyout;

  ahbsub_mem #(.MEMWORDS_LOG2(12), .WAITSTATES(0)) dut_a (
    .hclk(clk), .hresetn(a_rstn), .hsel(a_hsel), .haddr(a_haddr),
    .htrans(a_htrans), .hwrite(a_hwrite), .hsize(a_hsize), .hburst(a_hburst),
    .hmastlock(a_hmastlock), .hwstrb(a_hwstrb), .hwdata(a_hwdata),
    .hready(a_hready), .hrdata(a_hrdata), .hreadyout(a_hreadyout), .hresp(a_hresp)
  );

  ahbsub_mem #(.MEMWORDS_LOG2(12), .WAITSTATES(2)) dut_b (
    .hclk(clk), .hresetn(b_rstn), .hsel(b_hsel), .haddr(b_haddr),
    .htrans(b_htrans), .hwrite(b_hwrite), .hsize(b_hsize), .hburst(b_hburst),
    .hmastlock(b_hmastlock), .hwstrb(b_hwstrb), .hwdata(b_hwdata),
    .hready(b_hready), .hrdata(b_hrdata), .hreadyout(b_hreadyout), .hresp(b_hresp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_addr(input logic [31:0] a, input logic w, input logic [1:0] tr);
    a_hsel = 1'b1; a_haddr = a; a_hwrite = w; a_htrans = tr;
  endtask

  task automatic a_idle();
    a_hsel = 1'b0; a_htrans = 2'd0;
  endtask

  task automatic a_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    a_addr(a, 1'b1, 2'd2);
    step();
    a_idle();
    a_hwdata = d; a_hwstrb = s;
    step();
  endtask

  task automatic a_read(input logic [31:0] a, output logic [31:0] d);
    a_addr(a, 1'b0, 2'd2);
    step();
    a_idle();
    d = a_hrdata;
    step();
  endtask

  task automatic b_addr(input logic [31:0] a, input logic w);
    b_hsel = 1'b1; b_haddr = a; b_hwrite = w; b_htrans = 2'd2;
  endtask

  task automatic b_idle();
    b_hsel = 1'b0; b_htrans = 2'd0;
  endtask

  // Steps while B holds hreadyout low; returns the number of low cycles.
  task automatic b_wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 10 && b_hreadyout !== 1'b1; i++) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    a_rstn = 1'b0; b_rstn = 1'b0;
    a_hsel = 0; a_haddr = 0; a_htrans = 0; a_hwrite = 0; a_hsize = 3'd2;
    a_hburst = 3'd1; a_hmastlock = 0; a_hwstrb = 0; a_hwdata = 0;
    b_hsel = 0; b_haddr = 0; b_htrans = 0; b_hwrite = 0; b_hsize = 3'd2;
    b_hburst = 3'd0; b_hmastlock = 0; b_hwstrb = 0; b_hwdata = 0;
    step(); step();
    checks++; if (a_hreadyout !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", a_hreadyout); end
    checks++; if (a_hresp !== 1'b0) begin failures++; $display("FAIL rst_resp got=%b exp=0", a_hresp); end
    checks++; if (a_hrdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=00000000", a_hrdata); end
    checks++; if (b_hreadyout !== 1'b1) begin failures++; $display("FAIL rst_ready_b got=%b exp=1", b_hreadyout); end
    a_rstn = 1'b1; b_rstn = 1'b1;
    step();
  endtask

  task automatic test_zero_wait();
    a_addr(32'h0000_0010, 1'b1, 2'd2);
    step();
    checks++; if (a_hreadyout !== 1'b1) begin failures++; $display("FAIL zw_wr_ready got=%b exp=1", a_hreadyout); end
    a_idle();
    a_hwdata = 32'hDEAD_BEEF; a_hwstrb = 4'hF;
    step();
    a_addr(32'h0000_0010, 1'b0, 2'd2);
    step();
    a_idle();
    checks++; if (a_hreadyout !== 1'b1) begin failures++; $display("FAIL zw_rd_ready got=%b exp=1", a_hreadyout); end
    checks++; if (a_hrdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL zw_rdata got=%h exp=deadbeef", a_hrdata); end
    checks++; if (a_hresp !== 1'b0) begin failures++; $display("FAIL zw_resp got=%b exp=0", a_hresp); end
    step();
  endtask

  task automatic test_strobes();
    logic [31:0] d;
    a_write(32'h20, 32'h1122_3344, 4'hF);
    a_write(32'h20, 32'hAABB_CCDD, 4'h5);
    a_read(32'h20, d);
    checks++; if (d !== 32'h11BB_33DD) begin failures++; $display("FAIL strb_merge got=%h exp=11bb33dd", d); end
    a_write(32'h20, 32'h0000_0000, 4'h0);
    a_read(32'h20, d);
    checks++; if (d !== 32'h11BB_33DD) begin failures++; $display("FAIL strb_zero got=%h exp=11bb33dd", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    w[0] = 32'h0102_0304; w[1] = 32'hA5A5_A5A5; w[2] = 32'h0F0F_0F0F; w[3] = 32'h7654_3210;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) a_addr(32'h100 + 32'(4*k), 1'b1, (k == 0) ? 2'd2 : 2'd3);
      else       a_idle();
      if (k > 0) begin a_hwdata = w[k-1]; a_hwstrb = 4'hF; end
      step();
      checks++; if (a_hreadyout !== 1'b1) begin failures++; $display("FAIL burst_wr_ready beat=%0d got=%b exp=1", k, a_hreadyout); end
    end
    for (int k = 0; k < 4; k++) begin
      a_addr(32'h100 + 32'(4*k), 1'b0, (k == 0) ? 2'd2 : 2'd3);
      step();
      checks++; if (a_hrdata !== w[k]) begin failures++; $display("FAIL burst_rd beat=%0d got=%h exp=%h", k, a_hrdata, w[k]); end
    end
    a_idle();
    step();
    // write immediately followed by a read of the same word
    a_addr(32'h30, 1'b1, 2'd2);
    step();
    a_hwdata = 32'h1357_9BDF; a_hwstrb = 4'hF;
    a_addr(32'h30, 1'b0, 2'd2);
    step();
    a_idle();
    checks++; if (a_hrdata !== 32'h1357_9BDF) begin failures++; $display("FAIL bypass got=%h exp=13579bdf", a_hrdata); end
    step();
  endtask

  task automatic test_error();
    logic [31:0] d;
    a_write(32'h0, 32'hCAFE_F00D, 4'hF);
    a_addr(32'h0000_4000, 1'b0, 2'd2);
    step();
    a_idle();
`ifdef AHB_SUB_ERR_EN
    checks++; if ({a_hreadyout, a_hresp} !== 2'b01) begin failures++; $display("FAIL err_cycle1 got=%b exp=01", {a_hreadyout, a_hresp}); end
    step();
    checks++; if ({a_hreadyout, a_hresp} !== 2'b11) begin failures++; $display("FAIL err_cycle2 got=%b exp=11", {a_hreadyout, a_hresp}); end
    checks++; if (a_hrdata !== 32'h0) begin failures++; $display("FAIL err_rdata got=%h exp=00000000", a_hrdata); end
    step();
    checks++; if ({a_hreadyout, a_hresp} !== 2'b10) begin failures++; $display("FAIL err_after got=%b exp=10", {a_hreadyout, a_hresp}); end
    a_read(32'h0, d);
    checks++; if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL err_mem0 got=%h exp=cafef00d", d); end
`else
    checks++; if ({a_hreadyout, a_hresp} !== 2'b10) begin failures++; $display("FAIL alias_resp got=%b exp=10", {a_hreadyout, a_hresp}); end
    checks++; if (a_hrdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL alias_rdata got=%h exp=cafef00d", a_hrdata); end
    step();
    d = 32'h0;
    a_read(32'h0, d);
    checks++; if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL alias_mem0 got=%h exp=cafef00d", d); end
`endif
  endtask

  task automatic test_wait_states();
    int n;
    b_addr(32'h40, 1'b1);
    step();
    b_idle();
    b_hwdata = 32'h5A5A_1234; b_hwstrb = 4'hF;
    b_wait_ready(n);
    checks++; if (n != 2) begin failures++; $display("FAIL ws_wr_low got=%0d exp=2", n); end
    step();
    b_addr(32'h40, 1'b0);
    step();
    b_idle();
    checks++; if (b_hrdata !== 32'h0) begin failures++; $display("FAIL ws_hold got=%h exp=00000000", b_hrdata); end
    b_wait_ready(n);
    checks++; if (n != 2) begin failures++; $display("FAIL ws_rd_low got=%0d exp=2", n); end
    checks++; if (b_hrdata !== 32'h5A5A_1234) begin failures++; $display("FAIL ws_rdata got=%h exp=5a5a1234", b_hrdata); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    b_addr(32'h40, 1'b1);
    step();
    b_idle();
    b_hwdata = 32'hFFFF_FFFF; b_hwstrb = 4'hF;
    checks++; if (b_hreadyout !== 1'b0) begin failures++; $display("FAIL mid_in_wait got=%b exp=0", b_hreadyout); end
    #1 b_rstn = 1'b0;
    #1;
    checks++; if (b_hreadyout !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", b_hreadyout); end
    checks++; if (b_hresp !== 1'b0) begin failures++; $display("FAIL mid_rst_resp got=%b exp=0", b_hresp); end
    checks++; if (b_hrdata !== 32'h0) begin failures++; $display("FAIL mid_rst_rdata got=%h exp=00000000", b_hrdata); end
    step(); step();
    b_rstn = 1'b1;
    step();
    b_addr(32'h40, 1'b0);
    step();
    b_idle();
    b_wait_ready(n);
    checks++; if (b_hrdata !== 32'h5A5A_1234) begin failures++; $display("FAIL mid_discard got=%h exp=5a5a1234", b_hrdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_strobes();
    test_back_to_back();
    test_error();
    test_wait_states();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
